// File: rtl/reg_file_dump.sv
// reg_file_dump
//
// Reads one register file port to dump a range of registers. A start pulse
// walks the addresses from start_addr to end_addr, both included. Each
// {address, data} pair goes out on a valid/ready stream. The dump is used for
// debug, trace capture and end-of-test signatures.
//
// Optional feature: define REG_DUMP_CSUM_EN to get a running XOR signature of
// every accepted word on csum. When the macro is undefined, csum is tied to 0
// and no XOR logic is built.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       one-cycle dump request, sampled only when idle
//   start_addr  first register to dump
//   end_addr    last register to dump (inclusive, may wrap below start_addr)
//   rf_addr     read address driven to the register file port
//   rf_data     combinational read data from the register file
//   dout_valid  stream word valid
//   dout_ready  sink accepts word
//   dout_addr   register index of the current word
//   dout_data   register contents of the current word
//   dout_last   current word is the final one of the range
//   busy        high while fetching or presenting words
//   done        one-cycle pulse after the final word is accepted
//   csum        XOR signature of accepted words (0 unless REG_DUMP_CSUM_EN)

module reg_file_dump #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] csum
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  logic start_accept;
  logic handshake;

  assign start_accept = (state_q == StIdle) && start;
  assign handshake    = (state_q == StSend) && valid_q && dout_ready;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d   = start_addr;
          end_d   = end_addr;
          state_d = StLoad;
        end
      end

      StLoad: begin
        // Capture the register as it reads at this edge. Later writes do not
        // change a word that has already been captured.
        data_d  = rf_data;
        addr_d  = ptr_q;
        last_d  = (ptr_q == end_q);
        valid_d = 1'b1;
        state_d = StSend;
      end

      StSend: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = StDone;
          end else begin
            // The address wraps modulo the register count, which lets
            // end_addr sit below start_addr.
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = StLoad;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // The pointer only changes on start or on a handshake. rf_addr therefore
  // holds the last address outside LOAD.
  assign rf_addr    = ptr_q;
  assign dout_valid = valid_q;
  assign dout_addr  = addr_q;
  assign dout_data  = data_q;
  assign dout_last  = last_q;
  assign busy       = (state_q == StLoad) || (state_q == StSend);
  assign done       = (state_q == StDone);

`ifdef REG_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Clear on an accepted start and fold in each accepted word. The value is
  // held after the dump so it can be read until the next start.
  always_comb begin
    csum_d = csum_q;
    if (start_accept) begin
      csum_d = '0;
    end else if (handshake) begin
      csum_d = csum_q ^ data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`else
  logic unused_ctl;
  assign unused_ctl = start_accept ^ handshake;
  assign csum       = '0;
`endif

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed testbench for reg_file_dump, paired with a behavioural register file.

module tb_reg_file_dump;

  localparam int AW = 5;
  localparam int DW = 32;

`ifdef REG_DUMP_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW-1:0] dout_addr;
  logic [DW-1:0] dout_data;
  logic          dout_last;
  logic          busy;
  logic          done;
  logic [DW-1:0] csum;

  logic [DW-1:0] mem [0:31];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rf_data = mem[rf_addr];

  reg_file_dump #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_addr (dout_addr),
    .dout_data (dout_data),
    .dout_last (dout_last),
    .busy      (busy),
    .done      (done),
    .csum      (csum)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start      = 1'b1;
    start_addr = s;
    end_addr   = e;
    tick();
    start      = 1'b0;
    // Scramble the inputs after the latch. The DUT must have captured them.
    start_addr = ~s;
    end_addr   = ~e;
  endtask

  // Expects n words starting at s. The sink stalls for 3 cycles on word
  // stall_k (a negative value means no stall).
  task automatic dump_words(input logic [AW-1:0] s, input int n, input int stall_k);
    logic [AW-1:0] a;
    logic [DW-1:0] x;
    a = s;
    x = '0;
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      if (!dout_valid) check("rf_addr_load", rf_addr, a);
      while (!dout_valid && w < 8) begin
        tick();
        w++;
      end
      start = 1'b0;
      check("latency", w, 1);
      check("valid", dout_valid, 1);
      check("busy_send", busy, 1);
      check("addr", dout_addr, a);
      check("data", dout_data, mem[a]);
      check("last", dout_last, (k == n - 1));
      if (k == stall_k) begin
        dout_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          check("stall_valid", dout_valid, 1);
          check("stall_addr", dout_addr, a);
          check("stall_data", dout_data, mem[a]);
        end
        dout_ready = 1'b1;
      end
      x = x ^ mem[a];
      tick();
      check("valid_drop", dout_valid, 0);
      a = a + 1'b1;
    end
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("csum", csum, CsumEn ? x : '0);
    tick();
    check("done_pulse", done, 0);
    check("no_extra_word", dout_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i * 32'h1111_1111;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    dout_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_addr", dout_addr, 0);
    check("rst_data", dout_data, 0);
    check("rst_last", dout_last, 0);
    check("rst_csum", csum, 0);
    rst = 1'b0;
    tick();

    // Full dump of all 32 registers.
    do_start(5'd0, 5'd31);
    check("busy_load", busy, 1);
    dump_words(5'd0, 32, -1);

    // Single word.
    do_start(5'd5, 5'd5);
    dump_words(5'd5, 1, -1);

    // Wrap-around: 30, 31, 0, 1.
    do_start(5'd30, 5'd1);
    dump_words(5'd30, 4, -1);

    // Backpressure on word 2.
    do_start(5'd0, 5'd5);
    dump_words(5'd0, 6, 2);

    // Reset while word 4 is being presented.
    do_start(5'd0, 5'd31);
    repeat (9) tick();
    check("pre_rst_valid", dout_valid, 1);
    check("pre_rst_addr", dout_addr, 4);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_csum", csum, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);

    // A start raised while busy must be ignored.
    do_start(5'd10, 5'd12);
    start      = 1'b1;
    start_addr = 5'd20;
    end_addr   = 5'd25;
    dump_words(5'd10, 3, -1);
    check("ignored_start_idle", busy, 0);

    // Signature of two known words.
    mem[1] = 32'hA5A5_A5A5;
    mem[2] = 32'h0F0F_0F0F;
    do_start(5'd1, 5'd2);
    dump_words(5'd1, 2, -1);
    tick();
    tick();
    check("csum_held", csum, CsumEn ? 64'hAAAA_AAAA : 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
